golden_stamp: RTL and testbench

GOLDEN_STAMP -- requirements
Module: golden_stamp

---
 rtl/router_pkg.sv | 19 +
 rtl/golden_stamp_ctr.sv | 42 ++++
 rtl/golden_stamp.sv | 57 +++++
 tb/tb_golden_stamp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: flit layout and golden-stamp helper shared by the router input, arbiter and switch stages
package router_pkg;
    localparam int FLIT_W     = 32;
    localparam int GOLDEN_BIT = 0;
    localparam int VALID_BIT  = 1;
    localparam int PRIO_HI    = 19;
    localparam int PRIO_LO    = 15;
    localparam int TAG_HI     = 27;
    localparam int TAG_LO     = 20;
    localparam int TAG_W      = 8;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [TAG_W-1:0]  tag_t;

    // Empty slots collapse to all-zero; valid flits keep [31:1] and get a fresh golden bit.
    function automatic flit_t stamp(input flit_t f, input tag_t tag);
        return f[VALID_BIT] ? {f[FLIT_W-1:GOLDEN_BIT+1], f[TAG_HI:TAG_LO] == tag} : '0;
    endfunction
endpackage

// File: rtl/golden_stamp_ctr.sv
// golden_ctr: epoch counter that advances the golden tag once per epoch and flags the advance
module golden_ctr
    import router_pkg::*;
#(
    parameter int EPOCH_LEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [TAG_W-1:0] golden_tag,
    output logic             wrap
);
    logic [15:0]      ep_q, ep_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             wrap_q, wrap_d;
    logic             last;

    assign last = ep_q == 16'(EPOCH_LEN - 1);

    // Next state: stall freezes everything; wrap_q marks the first cycle the new tag is visible and survives stalls.
    always_comb begin
        ep_d   = stall ? ep_q : (last ? 16'd0 : ep_q + 16'd1);
        tag_d  = (stall || !last) ? tag_q : tag_q + TAG_W'(1);
        wrap_d = stall ? wrap_q : last;
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ep_q   <= '0;
            tag_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ep_q   <= ep_d;
            tag_q  <= tag_d;
            wrap_q <= wrap_d;
        end
    end

    assign golden_tag = tag_q;
    assign wrap       = wrap_q;
endmodule

// File: rtl/golden_stamp.sv
// golden_stamp: registers four router input flits, marking those whose tag matches the current golden tag
module golden_stamp
    import router_pkg::*;
#(
    parameter int EPOCH_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [FLIT_W-1:0] in_0,
    input  logic [FLIT_W-1:0] in_1,
    input  logic [FLIT_W-1:0] in_2,
    input  logic [FLIT_W-1:0] in_3,
    output logic [FLIT_W-1:0] out_0,
    output logic [FLIT_W-1:0] out_1,
    output logic [FLIT_W-1:0] out_2,
    output logic [FLIT_W-1:0] out_3,
    output logic [TAG_W-1:0]  golden_tag,
    output logic              epoch_tick
);
    flit_t in_a [4];
    flit_t out_q[4];
    flit_t out_d[4];
    logic  wrap;
    logic  tick_q, tick_d;

    assign in_a[0] = in_0;
    assign in_a[1] = in_1;
    assign in_a[2] = in_2;
    assign in_a[3] = in_3;

    golden_ctr #(.EPOCH_LEN(EPOCH_LEN)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .golden_tag (golden_tag),
        .wrap       (wrap)
    );

    for (genvar k = 0; k < 4; k++) begin : g_port
        // Stamp against the tag register value of this cycle; stall holds the slot.
        always_comb out_d[k] = stall ? out_q[k] : stamp(in_a[k], golden_tag);
        // Output register for this port.
        always_ff @(posedge clk) out_q[k] <= rst ? '0 : out_d[k];
    end

    // Tick lines up with the first outputs stamped by a new tag; a stalled cycle never ticks.
    always_comb tick_d = !stall && wrap;
    // Tick register.
    always_ff @(posedge clk) tick_q <= rst ? 1'b0 : tick_d;

    assign out_0      = out_q[0];
    assign out_1      = out_q[1];
    assign out_2      = out_q[2];
    assign out_3      = out_q[3];
    assign epoch_tick = tick_q;
endmodule

// File: tb/tb_golden_stamp.sv
// tb_golden_stamp: randomized golden-stamp checks against a cycle-counting reference model
module tb_golden_stamp;
    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
    logic [31:0] out_0, out_1, out_2, out_3;
    logic [7:0]  golden_tag;
    logic        epoch_tick;

    int          checks = 0;
    int          passes = 0;

    int           k = 0;
    logic [127:0] m_out = '0;
    logic         m_tick = 1'b0;
    logic [7:0]   m_tag = '0;

    golden_stamp #(.EPOCH_LEN(LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .in_0       (in_0),
        .in_1       (in_1),
        .in_2       (in_2),
        .in_3       (in_3),
        .out_0      (out_0),
        .out_1      (out_1),
        .out_2      (out_2),
        .out_3      (out_3),
        .golden_tag (golden_tag),
        .epoch_tick (epoch_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cur_tag();
        return 8'((k / LEN) % 256);
    endfunction

    function automatic logic [31:0] rand_flit(input logic [7:0] t);
        logic [31:0] f;
        f = $urandom;
        if ($urandom_range(0, 1) == 1) f[27:20] = t;
        f[1] = $urandom_range(0, 3) != 0;
        return f;
    endfunction

    function automatic logic [127:0] rand_bus(input logic [7:0] t);
        return {rand_flit(t), rand_flit(t), rand_flit(t), rand_flit(t)};
    endfunction

    task automatic cycle(input logic r, input logic s, input logic [127:0] din);
        logic [7:0]  st;
        logic [31:0] f;
        rst = r;
        stall = s;
        {in_3, in_2, in_1, in_0} = din;
        @(posedge clk);
        #1;
        if (r) begin
            m_out = '0;
            m_tick = 1'b0;
            k = 0;
        end else if (s) begin
            m_tick = 1'b0;
        end else begin
            st = cur_tag();
            k++;
            for (int i = 0; i < 4; i++) begin
                f = din[i*32 +: 32];
                m_out[i*32 +: 32] = f[1] ? {f[31:1], f[27:20] == st} : 32'h0;
            end
            m_tick = (k > 1) && ((k - 1) % LEN == 0);
        end
        m_tag = cur_tag();
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, {96'h0, 32'hFFFF_FFFF});
        cycle(1'b1, 1'b0, {96'h0, 32'hFFFF_FFFF});
        checks++;
        if ({out_3, out_2, out_1, out_0} !== 128'h0 || golden_tag !== 8'h00 || epoch_tick !== 1'b0)
            $display("FAIL reset_held out=%h tag=%h tick=%b want all zero", {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick);
        else passes++;
        cycle(1'b0, 1'b0, 128'h0);
        checks++;
        if ({out_3, out_2, out_1, out_0} !== 128'h0 || golden_tag !== 8'h00 || epoch_tick !== 1'b0)
            $display("FAIL reset_release out=%h tag=%h tick=%b want all zero", {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick);
        else passes++;
    endtask

    task automatic test_stamp();
        cycle(1'b0, 1'b0, {32'h0, 32'hABCD_0001, 32'h0010_0002, 32'h0000_0002});
        checks++;
        if (out_0 !== 32'h0000_0003 || out_1 !== 32'h0010_0002 || out_2 !== 32'h0 || out_3 !== 32'h0)
            $display("FAIL stamp_fixed out0=%h out1=%h out2=%h out3=%h want 00000003 00100002 0 0", out_0, out_1, out_2, out_3);
        else passes++;
        checks++;
        if ({out_3, out_2, out_1, out_0} !== m_out || golden_tag !== m_tag)
            $display("FAIL stamp_model out=%h tag=%h want out=%h tag=%h", {out_3, out_2, out_1, out_0}, golden_tag, m_out, m_tag);
        else passes++;
    endtask

    task automatic test_epoch_wrap();
        logic [127:0] d;
        cycle(1'b1, 1'b0, 128'h0);
        for (int n = 1; n <= 8; n++) begin
            d = rand_bus(8'h01);
            for (int i = 0; i < 4; i++) begin
                d[i*32 + 20 +: 8] = 8'h01;
                d[i*32 + 1] = 1'b1;
            end
            cycle(1'b0, 1'b0, d);
            checks++;
            if ({out_3[0], out_2[0], out_1[0], out_0[0]} !== {4{n >= 5 && n <= 8}} || epoch_tick !== (n == 5))
                $display("FAIL epoch_wrap n=%0d golden=%b tick=%b want golden=%b tick=%b", n,
                         {out_3[0], out_2[0], out_1[0], out_0[0]}, epoch_tick, {4{n >= 5 && n <= 8}}, n == 5);
            else passes++;
            checks++;
            if ({out_3, out_2, out_1, out_0} !== m_out || golden_tag !== m_tag || epoch_tick !== m_tick)
                $display("FAIL epoch_model n=%0d out=%h tag=%h tick=%b want out=%h tag=%h tick=%b", n,
                         {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick, m_out, m_tag, m_tick);
            else passes++;
        end
    endtask

    task automatic test_tag_wrap();
        cycle(1'b1, 1'b0, 128'h0);
        for (int n = 1; n <= 1024; n++) begin
            cycle(1'b0, 1'b0, rand_bus(cur_tag()));
            checks++;
            if ({out_3, out_2, out_1, out_0} !== m_out || golden_tag !== m_tag || epoch_tick !== m_tick)
                $display("FAIL tag_wrap_model n=%0d out=%h tag=%h tick=%b want out=%h tag=%h tick=%b", n,
                         {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick, m_out, m_tag, m_tick);
            else passes++;
            if (n == 1023) begin
                checks++;
                if (golden_tag !== 8'hFF) $display("FAIL tag_255 tag=%h want ff", golden_tag);
                else passes++;
            end
            if (n == 1024) begin
                checks++;
                if (golden_tag !== 8'h00) $display("FAIL tag_wrap_zero tag=%h want 00", golden_tag);
                else passes++;
            end
        end
    endtask

    task automatic test_stall();
        logic [127:0] held;
        cycle(1'b1, 1'b0, 128'h0);
        for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0, rand_bus(cur_tag()));
        held = {out_3, out_2, out_1, out_0};
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b1, rand_bus(cur_tag()));
            checks++;
            if ({out_3, out_2, out_1, out_0} !== held || golden_tag !== 8'h00 || epoch_tick !== 1'b0)
                $display("FAIL stall_hold n=%0d out=%h tag=%h tick=%b want out=%h tag=00 tick=0", n,
                         {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick, held);
            else passes++;
        end
        cycle(1'b0, 1'b0, rand_bus(cur_tag()));
        checks++;
        if (golden_tag !== 8'h01 || epoch_tick !== 1'b0)
            $display("FAIL stall_late_wrap tag=%h tick=%b want tag=01 tick=0", golden_tag, epoch_tick);
        else passes++;
        cycle(1'b0, 1'b0, rand_bus(cur_tag()));
        checks++;
        if (epoch_tick !== 1'b1 || {out_3, out_2, out_1, out_0} !== m_out)
            $display("FAIL stall_tick tick=%b out=%h want tick=1 out=%h", epoch_tick, {out_3, out_2, out_1, out_0}, m_out);
        else passes++;
    endtask

    task automatic test_reset_beats_stall();
        cycle(1'b1, 1'b0, 128'h0);
        for (int n = 0; n < 22; n++) cycle(1'b0, 1'b0, rand_bus(cur_tag()));
        checks++;
        if (golden_tag !== 8'h05) $display("FAIL rbs_setup tag=%h want 05", golden_tag);
        else passes++;
        cycle(1'b1, 1'b1, rand_bus(cur_tag()));
        checks++;
        if ({out_3, out_2, out_1, out_0} !== 128'h0 || golden_tag !== 8'h00 || epoch_tick !== 1'b0)
            $display("FAIL rbs_clear out=%h tag=%h tick=%b want all zero", {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick);
        else passes++;
        for (int n = 1; n <= 8; n++) begin
            cycle(1'b0, 1'b0, rand_bus(cur_tag()));
            checks++;
            if ({out_3, out_2, out_1, out_0} !== m_out || golden_tag !== m_tag || epoch_tick !== m_tick)
                $display("FAIL rbs_restart n=%0d out=%h tag=%h tick=%b want out=%h tag=%h tick=%b", n,
                         {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick, m_out, m_tag, m_tick);
            else passes++;
        end
    endtask

    task automatic test_random();
        cycle(1'b1, 1'b0, 128'h0);
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, rand_bus(cur_tag()));
            checks++;
            if ({out_3, out_2, out_1, out_0} !== m_out || golden_tag !== m_tag || epoch_tick !== m_tick)
                $display("FAIL random n=%0d out=%h tag=%h tick=%b want out=%h tag=%h tick=%b", n,
                         {out_3, out_2, out_1, out_0}, golden_tag, epoch_tick, m_out, m_tag, m_tick);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_stamp();
        test_epoch_wrap();
        test_tag_wrap();
        test_stall();
        test_reset_beats_stall();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
